ce_period_monitor: RTL and testbench
====================================

CE_PERIOD_MONITOR -- requirements
Module: ce_period_monitor

Interface
REQ-001 SHALL have parameter EXPECTED_PERIOD, 8 bits, default 32: nominal clk cycles between consecutive ce_in pulses.
REQ-002 SHALL have parameter TOLERANCE, 8 bits, default 1: allowed +/- deviation in cycles.
REQ-003 SHALL have parameter LOCK_COUNT, 4 bits, default 4: consecutive good periods required to lock; legal range 1..15.
REQ-004 SHALL require EXPECTED_PERIOD+TOLERANCE <= 254 and EXPECTED_PERIOD > TOLERANCE; violations are a configuration error.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 ce_in  input  1  single-cycle clock-enable pulse stream under test, synchronous to clk.
REQ-008 locked  output  1  high while the stream is within tolerance.
REQ-009 period_out  output  8  last measured period in clk cycles.
REQ-010 period_valid  output  1  one-cycle strobe: period_out updated.
REQ-011 err_short  output  1  one-cycle strobe: period below EXPECTED_PERIOD-TOLERANCE.
REQ-012 err_long  output  1  one-cycle strobe: period above EXPECTED_PERIOD+TOLERANCE, or timeout.
REQ-013 err_count  output  16  saturating count of errors detected while locked.

Function
REQ-014 SHALL keep an 8-bit interval counter, cleared to 0 in any cycle with ce_in=1, incremented otherwise, saturating at 255.
REQ-015 Measured period SHALL equal counter+1 sampled in a ce_in=1 cycle (pulses every N clocks give period N; back-to-back pulses give 1).
REQ-016 Classification: good if EXPECTED_PERIOD-TOLERANCE <= period <= EXPECTED_PERIOD+TOLERANCE; short if below; long if above.
REQ-017 period_out, period_valid, err_short, err_long, locked and err_count SHALL all be registered, updating exactly one clk after the ce_in cycle (or timeout cycle) that causes them.
REQ-018 States: IDLE, ACQUIRE, LOCKED.
REQ-019 IDLE: counter value ignored, no period_valid, no errors; ce_in=1 -> ACQUIRE with good_cnt=0.
REQ-020 ACQUIRE: ce_in with good period -> period_valid, good_cnt+1; when good_cnt reaches LOCK_COUNT -> LOCKED, locked asserted in the same output cycle as that period_valid.
REQ-021 ACQUIRE: ce_in with short/long period -> period_valid plus err_short/err_long, good_cnt=0, remain ACQUIRE; err_count unchanged.
REQ-022 LOCKED: good period -> period_valid only; short/long period -> period_valid, matching error strobe, err_count+1, locked deasserts, -> ACQUIRE with good_cnt=0.
REQ-023 Timeout: in ACQUIRE or LOCKED, a cycle with ce_in=0 and counter+1 = EXPECTED_PERIOD+TOLERANCE+1 SHALL strobe err_long (no period_valid), -> IDLE, locked deasserts; err_count+1 only if it was LOCKED.
REQ-024 Simultaneous: ce_in=1 in the timeout-threshold cycle is a long period per REQ-021/022 (restart from this pulse in ACQUIRE), not a timeout.
REQ-025 err_short and err_long SHALL never assert in the same cycle; at most one error event per clk.
REQ-026 err_count SHALL hold at 16'hFFFF once reached.
REQ-027 Timeout SHALL fire at most once per loss; no further strobes until ce_in resumes.

Reset
REQ-028 rst=1 SHALL force IDLE, counter=0, good_cnt=0, locked=0, period_out=0, period_valid=0, err_short=0, err_long=0, err_count=0 on the next clk edge.
REQ-029 rst mid-period or mid-lock SHALL discard the partial interval; the first ce_in after rst is treated as IDLE->ACQUIRE with no period_valid.
REQ-030 rst asserted coincident with ce_in=1 SHALL take priority; that pulse is ignored.

Verification
REQ-031 Defaults, ce_in every 32 clks -> period_valid with period_out=32 from 2nd pulse on; locked rises 1 clk after 5th pulse (4th good period); err_count=0.
REQ-032 Locked, one interval of 30 -> err_short strobe, period_out=30, locked=0, err_count=1; relock after 4 further good 32-periods.
REQ-033 Locked, ce_in stopped -> err_long 1 clk after counter+1 hits 34 (34th clk after last pulse), locked=0, state IDLE, err_count=1, no more strobes.
REQ-034 Locked, next pulse arrives exactly at 34 clks -> err_long with period_valid, period_out=34, state ACQUIRE (not IDLE).
REQ-035 ce_in held high continuously in ACQUIRE -> err_short every cycle, period_out=1, never locked; rst mid-stream -> all outputs 0 next clk.
REQ-036 Force err_count to 16'hFFFF via repeated locked errors -> stays 16'hFFFF.

Source files
------------

// File: rtl/ce_period_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ce_period_monitor
// Purpose  : Measures ce_in pulse spacing, locks onto the nominal period and
//            flags short/long intervals and loss of the pulse stream.
// Revision : 1.0 - initial release
// ============================================================================
module ce_period_monitor #(
  parameter logic [7:0] EXPECTED_PERIOD = 8'd32,
  parameter logic [7:0] TOLERANCE       = 8'd1,
  parameter logic [3:0] LOCK_COUNT      = 4'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_in,
  output logic        locked,
  output logic [7:0]  period_out,
  output logic        period_valid,
  output logic        err_short,
  output logic        err_long,
  output logic [15:0] err_count
);

  localparam logic [8:0] PERIOD_MIN     = {1'b0, EXPECTED_PERIOD} - {1'b0, TOLERANCE};
  localparam logic [8:0] PERIOD_MAX     = {1'b0, EXPECTED_PERIOD} + {1'b0, TOLERANCE};
  localparam logic [8:0] TIMEOUT_PERIOD = PERIOD_MAX + 9'd1;

  generate
    if ((PERIOD_MAX > 9'd254) || (EXPECTED_PERIOD <= TOLERANCE) || (LOCK_COUNT == 4'd0)) begin : g_cfg_error
      $error("ce_period_monitor: illegal EXPECTED_PERIOD/TOLERANCE/LOCK_COUNT combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  counter_q, counter_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        locked_q, locked_d;
  logic [7:0]  period_out_q, period_out_d;
  logic        period_valid_q, period_valid_d;
  logic        err_short_q, err_short_d;
  logic        err_long_q, err_long_d;
  logic [15:0] err_count_q, err_count_d;

  logic [8:0]  measured_period;
  logic        is_short;
  logic        is_long;
  logic        timeout;
  logic [15:0] err_count_inc;

  // Counter never exceeds the timeout threshold outside IDLE, so 9 bits
  // here only matter for the IDLE case where the value is ignored.
  assign measured_period = {1'b0, counter_q} + 9'd1;
  assign is_short        = measured_period < PERIOD_MIN;
  assign is_long         = measured_period > PERIOD_MAX;
  assign timeout         = !ce_in && (measured_period == TIMEOUT_PERIOD);
  assign err_count_inc   = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;

  always_comb begin
    state_d        = state_q;
    counter_d      = ce_in ? 8'd0 : ((counter_q == 8'hFF) ? counter_q : counter_q + 8'd1);
    good_cnt_d     = good_cnt_q;
    period_out_d   = period_out_q;
    period_valid_d = 1'b0;
    err_short_d    = 1'b0;
    err_long_d     = 1'b0;
    err_count_d    = err_count_q;

    case (state_q)
      S_IDLE: begin
        if (ce_in) begin
          state_d    = S_ACQUIRE;
          good_cnt_d = 4'd0;
        end
      end

      S_ACQUIRE: begin
        if (ce_in) begin
          period_valid_d = 1'b1;
          period_out_d   = measured_period[7:0];
          if (is_short || is_long) begin
            err_short_d = is_short;
            err_long_d  = is_long;
            good_cnt_d  = 4'd0;
          end else begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 == LOCK_COUNT) begin
              state_d = S_LOCKED;
            end
          end
        end else if (timeout) begin
          err_long_d = 1'b1;
          state_d    = S_IDLE;
        end
      end

      S_LOCKED: begin
        if (ce_in) begin
          period_valid_d = 1'b1;
          period_out_d   = measured_period[7:0];
          if (is_short || is_long) begin
            err_short_d = is_short;
            err_long_d  = is_long;
            err_count_d = err_count_inc;
            good_cnt_d  = 4'd0;
            state_d     = S_ACQUIRE;
          end
        end else if (timeout) begin
          err_long_d  = 1'b1;
          err_count_d = err_count_inc;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      counter_q      <= 8'd0;
      good_cnt_q     <= 4'd0;
      locked_q       <= 1'b0;
      period_out_q   <= 8'd0;
      period_valid_q <= 1'b0;
      err_short_q    <= 1'b0;
      err_long_q     <= 1'b0;
      err_count_q    <= 16'd0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      good_cnt_q     <= good_cnt_d;
      locked_q       <= locked_d;
      period_out_q   <= period_out_d;
      period_valid_q <= period_valid_d;
      err_short_q    <= err_short_d;
      err_long_q     <= err_long_d;
      err_count_q    <= err_count_d;
    end
  end

  assign locked       = locked_q;
  assign period_out   = period_out_q;
  assign period_valid = period_valid_q;
  assign err_short    = err_short_q;
  assign err_long     = err_long_q;
  assign err_count    = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ce_period_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ce_period_monitor
// Purpose  : Scenario tasks plus randomized intervals against a cycle-time model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ce_period_monitor;

  localparam int EXP = 32;
  localparam int TOL = 1;
  localparam int LCK = 4;
  localparam int LO  = EXP - TOL;
  localparam int HI  = EXP + TOL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_in = 1'b0;
  logic        locked;
  logic [7:0]  period_out;
  logic        period_valid;
  logic        err_short;
  logic        err_long;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ce_period_monitor #(
    .EXPECTED_PERIOD(8'd32),
    .TOLERANCE      (8'd1),
    .LOCK_COUNT     (4'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce_in       (ce_in),
    .locked      (locked),
    .period_out  (period_out),
    .period_valid(period_valid),
    .err_short   (err_short),
    .err_long    (err_long),
    .err_count   (err_count)
  );

  // Reference model: tracks absolute edge index of the last pulse and
  // derives periods as time differences.
  int   m_mode;   // 0 idle, 1 acquiring, 2 locked
  int   m_good;
  int   m_last;
  int   m_cyc = 0;
  int   m_period;
  int   m_ec;
  logic m_pv, m_es, m_el;

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic void model_edge(input logic c, input logic r);
    int p;
    m_cyc++;
    m_pv = 1'b0; m_es = 1'b0; m_el = 1'b0;
    if (r) begin
      m_mode = 0; m_good = 0; m_period = 0; m_ec = 0;
      return;
    end
    if (c) begin
      p = m_cyc - m_last;
      m_last = m_cyc;
      if (m_mode == 0) begin
        m_mode = 1; m_good = 0;
      end else begin
        m_pv = 1'b1;
        m_period = p;
        if (p >= LO && p <= HI) begin
          if (m_mode == 1) begin
            m_good++;
            if (m_good == LCK) m_mode = 2;
          end
        end else begin
          if (p < LO) m_es = 1'b1; else m_el = 1'b1;
          if (m_mode == 2) m_ec = sat_inc(m_ec);
          m_mode = 1; m_good = 0;
        end
      end
    end else if (m_mode != 0 && (m_cyc - m_last) == HI + 1) begin
      m_el = 1'b1;
      if (m_mode == 2) m_ec = sat_inc(m_ec);
      m_mode = 0;
    end
  endfunction

  function automatic logic [27:0] got();
    return {locked, period_out, period_valid, err_short, err_long, err_count};
  endfunction

  function automatic logic [27:0] want();
    return {(m_mode == 2), 8'(m_period), m_pv, m_es, m_el, 16'(m_ec)};
  endfunction

  task automatic drive(input logic c, input logic r);
    @(negedge clk);
    ce_in = c;
    rst   = r;
    @(posedge clk);
    model_edge(c, r);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1);
      total++;
      if (got() !== 28'd0) begin
        bad++;
        $display("FAIL reset_state cyc=%0d got=%h want=%h", m_cyc, got(), 28'd0);
      end
    end
    drive(1'b1, 1'b0);
    total++;
    if (got() !== want() || period_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_pulse_after_reset got=%h want=%h", got(), want());
    end
  endtask

  task automatic test_lock();
    int iv[$] = '{32, 32, 32, 32, 32};
    foreach (iv[i]) begin
      for (int k = 1; k <= iv[i]; k++) begin
        drive(k == iv[i], 1'b0);
        total++;
        if (got() !== want()) begin
          bad++;
          $display("FAIL lock_seq cyc=%0d got=%h want=%h", m_cyc, got(), want());
        end
      end
      if (i == 2) begin
        total++;
        if (locked !== 1'b0) begin
          bad++;
          $display("FAIL lock_early got=%b want=0", locked);
        end
      end
      if (i == 3) begin
        total++;
        if ({locked, period_valid, period_out, err_count} !== {1'b1, 1'b1, 8'd32, 16'd0}) begin
          bad++;
          $display("FAIL lock_rise got=%b/%b/%0d/%0d want=1/1/32/0", locked, period_valid, period_out, err_count);
        end
      end
    end
  endtask

  task automatic test_short();
    int iv[$] = '{30, 32, 32, 32, 32};
    foreach (iv[i]) begin
      for (int k = 1; k <= iv[i]; k++) begin
        drive(k == iv[i], 1'b0);
        total++;
        if (got() !== want()) begin
          bad++;
          $display("FAIL short_seq cyc=%0d got=%h want=%h", m_cyc, got(), want());
        end
      end
      if (i == 0) begin
        total++;
        if ({err_short, err_long, period_out, locked, err_count} !== {1'b1, 1'b0, 8'd30, 1'b0, 16'd1}) begin
          bad++;
          $display("FAIL short_err got=%b%b/%0d/%b/%0d want=10/30/0/1", err_short, err_long, period_out, locked, err_count);
        end
      end
    end
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL short_relock got=%b want=1", locked);
    end
  endtask

  task automatic test_timeout();
    int strobes = 0;
    for (int k = 1; k <= 60; k++) begin
      drive(1'b0, 1'b0);
      total++;
      if (got() !== want() || err_long !== (k == 34)) begin
        bad++;
        $display("FAIL timeout_seq k=%0d got=%h want=%h", k, got(), want());
      end
      if (err_long) strobes++;
    end
    total++;
    if (strobes != 1 || locked !== 1'b0 || err_count !== 16'd2) begin
      bad++;
      $display("FAIL timeout_once strobes=%0d locked=%b cnt=%0d want 1/0/2", strobes, locked, err_count);
    end
  endtask

  task automatic test_exact34();
    int iv[$] = '{1, 32, 32, 32, 32, 34, 32};
    foreach (iv[i]) begin
      for (int k = 1; k <= iv[i]; k++) begin
        drive(k == iv[i], 1'b0);
        total++;
        if (got() !== want()) begin
          bad++;
          $display("FAIL exact34_seq cyc=%0d got=%h want=%h", m_cyc, got(), want());
        end
      end
      if (i == 5) begin
        total++;
        if ({period_valid, err_long, err_short, period_out, locked} !== {1'b1, 1'b1, 1'b0, 8'd34, 1'b0}) begin
          bad++;
          $display("FAIL exact34_long got=%b%b%b/%0d/%b want=110/34/0", period_valid, err_long, err_short, period_out, locked);
        end
      end
      if (i == 6) begin
        total++;
        if (period_valid !== 1'b1 || period_out !== 8'd32) begin
          bad++;
          $display("FAIL exact34_acquire got=%b/%0d want=1/32", period_valid, period_out);
        end
      end
    end
  endtask

  task automatic test_continuous();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0);
      total++;
      if (got() !== want() || (k > 0 && {err_short, period_out, locked} !== {1'b1, 8'd1, 1'b0})) begin
        bad++;
        $display("FAIL continuous k=%0d got=%h want=%h", k, got(), want());
      end
    end
    drive(1'b1, 1'b1);
    total++;
    if (got() !== 28'd0) begin
      bad++;
      $display("FAIL continuous_rst got=%h want=0", got());
    end
  endtask

  task automatic test_random();
    int n;
    int sel;
    drive(1'b0, 1'b1);
    for (int i = 0; i < 70; i++) begin
      sel = int'($urandom_range(0, 19));
      if (sel < 12)      n = int'($urandom_range(LO, HI));
      else if (sel < 17) n = int'($urandom_range(1, 40));
      else               n = 45;
      for (int k = 1; k <= n; k++) begin
        drive(k == n, ($urandom_range(0, 499) == 0));
        total++;
        if (got() !== want()) begin
          bad++;
          $display("FAIL random cyc=%0d got=%h want=%h", m_cyc, got(), want());
        end
      end
    end
  endtask

  task automatic test_saturate();
    int iv[$] = '{1, 32, 32, 32, 32, 30, 32, 32, 32, 32, 30, 32, 32, 32, 32, 30};
    drive(1'b0, 1'b1);
    foreach (iv[i]) begin
      for (int k = 1; k <= iv[i]; k++) begin
        if (i == 5 && k == 1) begin
          force dut.err_count_q = 16'hFFFE;
          m_ec = 65534;
        end
        drive(k == iv[i], 1'b0);
        if (i == 5 && k == 1) release dut.err_count_q;
        total++;
        if (got() !== want()) begin
          bad++;
          $display("FAIL saturate_seq cyc=%0d got=%h want=%h", m_cyc, got(), want());
        end
      end
    end
    total++;
    if (err_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL saturate_hold got=%h want=ffff", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_short();
    test_timeout();
    test_exact34();
    test_continuous();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d", m_cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
